// File: rtl/insitu_monitor_array.sv
// In-situ timing-error monitor array.
// Each channel watches one data-path node. An edge on the node while
// detec_window is high is a late transition. Such an edge sets a capture
// flop that is clocked by the node itself. The clk & ~delay_clk pulse clears
// the capture flops every cycle. Captured hits are sampled on posedge clk and
// pass through a synchronizer. They then drive sticky flags, saturating
// counters, a threshold alarm and a first-error latch.
//
// Ports:
//   clk            system clock / detection-phase reference
//   reset          asynchronous, active-high reset
//   delay_clk      delayed copy of clk (forms the capture-clear pulse)
//   detec_window   detection window, high = late transitions are errors
//   monitor_signal monitored nodes, one bit per channel
//   ch_enable      per-channel enable
//   edge_mode      00 none, 01 rising, 10 falling, 11 both
//   clear          synchronous clear of flags, counters, first-error latch
//   warn_thresh    alarm threshold (0 disables the alarm)
//   warning_signal raw OR of enabled capture flops (unsynchronized)
//   err_flag       sticky per-channel error flags
//   err_count      per-channel counters, channel i at [i*CNT_W +: CNT_W]
//   alarm          any enabled counter >= warn_thresh
//   first_valid    first-error latch valid
//   first_ch       first-error channel index
module insitu_monitor_array #(
    parameter int unsigned N_CH        = 8,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    delay_clk,
    input  logic                                    detec_window,
    input  logic [N_CH-1:0]                         monitor_signal,
    input  logic [N_CH-1:0]                         ch_enable,
    input  logic [1:0]                              edge_mode,
    input  logic                                    clear,
    input  logic [CNT_W-1:0]                        warn_thresh,
    output logic                                    warning_signal,
    output logic [N_CH-1:0]                         err_flag,
    output logic [N_CH*CNT_W-1:0]                   err_count,
    output logic                                    alarm,
    output logic                                    first_valid,
    output logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] first_ch
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Capture-clear pulse. A path whose edge is disabled is held cleared.
    logic clr_pulse;
    logic rise_clr;
    logic fall_clr;
    assign clr_pulse = clk & ~delay_clk;
    assign rise_clr  = clr_pulse | reset | ~edge_mode[0];
    assign fall_clr  = clr_pulse | reset | ~edge_mode[1];

    logic [N_CH-1:0]  raw_hit;
    logic [CNT_W-1:0] cnt_q [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic rise_q;
        logic fall_q;

        // IDLE (cleared) -> ARMED (pulse released) -> HIT (edge in window).
        // An edge outside the window loads 0, so the path stays armed.
        always_ff @(posedge monitor_signal[g] or posedge rise_clr) begin
            if (rise_clr) rise_q <= 1'b0;
            else          rise_q <= detec_window;
        end

        always_ff @(negedge monitor_signal[g] or posedge fall_clr) begin
            if (fall_clr) fall_q <= 1'b0;
            else          fall_q <= detec_window;
        end

        assign raw_hit[g] = (rise_q | fall_q) & ch_enable[g];
        assign err_count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign warning_signal = |raw_hit;

    // The capture flops update by non-blocking assignment. The sample
    // therefore holds the pre-clear value even though the clear pulse starts
    // on the same edge.
    logic [N_CH-1:0] samp_q;
    logic [N_CH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q <= '0;
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            samp_q    <= raw_hit;
            sync_q[0] <= samp_q;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    logic [N_CH-1:0] event_hit;
    assign event_hit = sync_q[SYNC_STAGES-1] & ch_enable;

    logic [N_CH-1:0]  flag_q, flag_d;
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic             alarm_q, alarm_d;
    logic             first_valid_q, first_valid_d;
    logic [CH_W-1:0]  first_ch_q, first_ch_d;
    logic [CH_W-1:0]  low_idx;
    logic             low_found;

    always_comb begin
        // A clear in the same cycle as an event still records the event.
        flag_d = (clear ? '0 : flag_q) | event_hit;

        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i] = clear ? '0 : cnt_q[i];
            if (event_hit[i] && (cnt_d[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_d[i] + 1'b1;
        end

        low_idx   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (event_hit[i] && !low_found) begin
                low_idx   = CH_W'(i);
                low_found = 1'b1;
            end
        end

        first_valid_d = first_valid_q & ~clear;
        first_ch_d    = clear ? '0 : first_ch_q;
        if (low_found && !first_valid_d) begin
            first_valid_d = 1'b1;
            first_ch_d    = low_idx;
        end

        // The alarm compares the registered counters, so it lags a crossing by one cycle.
        alarm_d = 1'b0;
        if (warn_thresh != '0) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (ch_enable[i] && (cnt_q[i] >= warn_thresh)) alarm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q        <= '0;
            alarm_q       <= 1'b0;
            first_valid_q <= 1'b0;
            first_ch_q    <= '0;
            for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            flag_q        <= flag_d;
            alarm_q       <= alarm_d;
            first_valid_q <= first_valid_d;
            first_ch_q    <= first_ch_d;
            for (int unsigned i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign err_flag    = flag_q;
    assign alarm       = alarm_q;
    assign first_valid = first_valid_q;
    assign first_ch    = first_ch_q;

endmodule

// File: tb/tb_insitu_monitor_array.sv
// Testbench for insitu_monitor_array (N_CH=8, CNT_W=4, SYNC_STAGES=2).
// Directed scenarios run first, then randomized traffic. All traffic is
// compared against a transaction-level model. The model holds a queue of hit
// vectors that mature SYNC_STAGES+1 edges after sampling, plus arrays of
// expected flags and counts.
module tb_insitu_monitor_array;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SYNC  = 2;
    localparam int          CMAX  = 15;

    logic                  clk, reset, delay_clk, detec_window, clear;
    logic [N_CH-1:0]       monitor_signal, ch_enable;
    logic [1:0]            edge_mode;
    logic [CNT_W-1:0]      warn_thresh;
    logic                  warning_signal, alarm, first_valid;
    logic [N_CH-1:0]       err_flag;
    logic [N_CH*CNT_W-1:0] err_count;
    logic [2:0]            first_ch;

    insitu_monitor_array #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .delay_clk      (delay_clk),
        .detec_window   (detec_window),
        .monitor_signal (monitor_signal),
        .ch_enable      (ch_enable),
        .edge_mode      (edge_mode),
        .clear          (clear),
        .warn_thresh    (warn_thresh),
        .warning_signal (warning_signal),
        .err_flag       (err_flag),
        .err_count      (err_count),
        .alarm          (alarm),
        .first_valid    (first_valid),
        .first_ch       (first_ch)
    );

    // Posedge at 5, 15, ...; delay_clk lags clk by 2.
    initial begin
        clk = 1'b0;
        delay_clk = 1'b0;
        forever begin
            #5 clk = 1'b1;
            #2 delay_clk = 1'b1;
            #3 clk = 1'b0;
            #2 delay_clk = 1'b0;
            #3;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [N_CH-1:0] m_flag;
    int              m_cnt [N_CH];
    logic            m_alarm, m_fv;
    int              m_fch;
    logic [N_CH-1:0] pipe [$];

    task automatic model_reset();
        m_flag  = '0;
        m_alarm = 1'b0;
        m_fv    = 1'b0;
        m_fch   = 0;
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        pipe.delete();
    endtask

    // Applies one clock edge to the model.
    task automatic model_edge(input logic [N_CH-1:0] hit, input logic clr);
        logic [N_CH-1:0] ev;
        logic            new_alarm;
        ev = '0;
        pipe.push_back(hit);
        if (pipe.size() > SYNC + 1) ev = pipe.pop_front() & ch_enable;
        new_alarm = 1'b0;
        for (int i = 0; i < N_CH; i++)
            if (warn_thresh != 0 && ch_enable[i] && m_cnt[i] >= int'(warn_thresh))
                new_alarm = 1'b1;
        if (clr) begin
            m_flag = '0;
            m_fv   = 1'b0;
            m_fch  = 0;
            for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        end
        m_flag = m_flag | ev;
        for (int i = 0; i < N_CH; i++)
            if (ev[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        if (ev != 0 && !m_fv) begin
            m_fv = 1'b1;
            for (int i = N_CH - 1; i >= 0; i--) if (ev[i]) m_fch = i;
        end
        m_alarm = new_alarm;
    endtask

    task automatic check_state(input string where);
        logic [N_CH*CNT_W-1:0] exp_cnt;
        for (int i = 0; i < N_CH; i++) exp_cnt[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
        check({where, " err_flag"}, 64'(err_flag), 64'(m_flag));
        check({where, " err_count"}, 64'(err_count), 64'(exp_cnt));
        check({where, " alarm"}, 64'(alarm), 64'(m_alarm));
        check({where, " first_valid"}, 64'(first_valid), 64'(m_fv));
        check({where, " first_ch"}, 64'(first_ch), 64'(m_fv ? m_fch : 0));
    endtask

    // Toggles the selected nodes and returns the channels expected to capture a hit.
    task automatic apply_edges(input logic [N_CH-1:0] tog, input logic win,
                               output logic [N_CH-1:0] hit);
        hit = '0;
        for (int i = 0; i < N_CH; i++)
            if (tog[i])
                hit[i] = win & ch_enable[i] &
                         (monitor_signal[i] ? edge_mode[1] : edge_mode[0]);
        monitor_signal = monitor_signal ^ tog;
    endtask

    // Entered and left at 1 time unit after a posedge.
    task automatic run_cycle(input logic [N_CH-1:0] tog, input logic win, input logic clr);
        logic [N_CH-1:0] hit;
        clear = clr;
        #3 detec_window = win;
        #2 apply_edges(tog, win, hit);
        #1 check("warning_signal", 64'(warning_signal), 64'(|hit));
        @(posedge clk);
        model_edge(hit, clr);
        #1 check_state("cycle");
        clear = 1'b0;
    endtask

    // Captures fresh hits, then asserts reset before they can be sampled.
    task automatic reset_mid(input logic [N_CH-1:0] tog, input logic win);
        logic [N_CH-1:0] hit;
        clear = 1'b0;
        #3 detec_window = win;
        #2 apply_edges(tog, win, hit);
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("reset warning_signal", 64'(warning_signal), 64'd0);
        check_state("reset");
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) run_cycle('0, 1'b0, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        detec_window   = 1'b0;
        clear          = 1'b0;
        monitor_signal = '0;
        ch_enable      = '1;
        edge_mode      = 2'b11;
        warn_thresh    = '0;
        model_reset();
        #2;
        check("reset warning_signal", 64'(warning_signal), 64'd0);
        check_state("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Rising edge on ch3 inside the window, with both edges enabled.
        run_cycle(8'h08, 1'b1, 1'b0);
        idle(4);
        check("ch3 flag", 64'(err_flag), 64'h08);
        check("ch3 first_ch", 64'(first_ch), 64'd3);

        // Rising-only mode: a rise outside the window, then a fall inside it.
        edge_mode = 2'b01;
        run_cycle('0, 1'b0, 1'b1);
        run_cycle(8'h01, 1'b0, 1'b0);
        run_cycle(8'h01, 1'b1, 1'b0);
        idle(4);
        check("mode01 counts", 64'(err_count), 64'd0);

        // Saturation, and the alarm at threshold 3.
        edge_mode   = 2'b11;
        warn_thresh = 4'd3;
        run_cycle('0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) run_cycle(8'h20, 1'b1, 1'b0);
        idle(4);
        check("ch5 saturated", 64'(err_count[5*CNT_W +: CNT_W]), 64'd15);
        check("alarm held", 64'(alarm), 64'd1);

        // Simultaneous ch2/ch6 events, then a clear that lands on a ch6 event.
        warn_thresh = '0;
        run_cycle('0, 1'b0, 1'b1);
        run_cycle(8'h44, 1'b1, 1'b0);
        idle(4);
        check("dual first_ch", 64'(first_ch), 64'd2);
        run_cycle(8'h40, 1'b1, 1'b0);
        idle(2);
        run_cycle('0, 1'b0, 1'b1);
        check("clear+event count", 64'(err_count), 64'h0100_0000);
        check("clear+event first_ch", 64'(first_ch), 64'd6);

        // A masked channel, then a reset during counting.
        ch_enable = 8'hFD;
        run_cycle('0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) run_cycle(8'h02, 1'b1, 1'b0);
        idle(4);
        check("masked ch1 flag", 64'(err_flag[1]), 64'd0);
        for (int k = 0; k < 5; k++) run_cycle(8'h10, 1'b1, 1'b0);
        reset_mid(8'h10, 1'b1);
        idle(6);
        check("post-reset count", 64'(err_count), 64'd0);

        // Randomized traffic.
        ch_enable = '1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) edge_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) ch_enable = 8'($urandom);
            if ($urandom_range(0, 19) == 0) warn_thresh = 4'($urandom);
            if ($urandom_range(0, 99) == 0)
                reset_mid(8'($urandom), 1'b1);
            else
                run_cycle(8'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/insitu_monitor_array.md
INSITU_MONITOR_ARRAY -- requirements
Module: insitu_monitor_array

Interface
REQ-001 Parameter N_CH, default 8, number of monitored channels (1..32).
REQ-002 Parameter CNT_W, default 8, width of each per-channel error counter (2..16).
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth into clk domain (2..3).
REQ-004 clk  input  1  system clock; also the detection-phase reference.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 delay_clk  input  1  delayed copy of clk; clk & ~delay_clk forms the capture-clear pulse.
REQ-007 detec_window  input  1  detection window; high = late transitions are errors.
REQ-008 monitor_signal  input  N_CH  monitored data-path nodes, one bit per channel.
REQ-009 ch_enable  input  N_CH  per-channel enable; 0 masks flag, counter, alarm and warning.
REQ-010 edge_mode  input  2  00 none, 01 rising only, 10 falling only, 11 both edges.
REQ-011 clear  input  1  synchronous pulse; clears flags, counters, first-error latch.
REQ-012 warn_thresh  input  CNT_W  alarm threshold; 0 disables alarm.
REQ-013 warning_signal  output  1  raw OR of all enabled channel capture flops (unsynchronized).
REQ-014 err_flag  output  N_CH  sticky synchronized per-channel error flags.
REQ-015 err_count  output  N_CH*CNT_W  per-channel counters, channel i at bits [i*CNT_W +: CNT_W].
REQ-016 alarm  output  1  registered; high when any enabled counter >= warn_thresh (warn_thresh != 0).
REQ-017 first_valid / first_ch  output  1 / $clog2(N_CH)  first-error latch valid and channel index.

Function
REQ-018 Per channel: a rise capture flop and a fall capture flop; each is clocked by its monitor_signal edge, loads detec_window, and is asynchronously cleared by (clk & ~delay_clk) | reset.
REQ-019 A capture flop whose edge is disabled by edge_mode is held cleared.
REQ-020 Channel raw hit = (rise_q | fall_q) & ch_enable[i]; warning_signal = OR of raw hits, purely combinational.
REQ-021 Raw hits are sampled on posedge clk before the clear pulse takes effect, then passed through SYNC_STAGES flops; hit_sync latency = SYNC_STAGES + 1 clk edges after the sampling edge.
REQ-022 hit_sync high for one cycle = one error event; err_flag[i] sets and stays set until clear or reset.
REQ-023 err_count[i] increments by 1 per event and saturates at 2^CNT_W-1 (no wrap).
REQ-024 clear and event in the same cycle: flag ends 1, counter ends 1 (event survives clear); first latch reloads with that channel.
REQ-025 first-error latch: on the first event after reset/clear, first_valid=1 and first_ch = lowest index among simultaneous events; frozen until clear.
REQ-026 alarm registered one cycle after the counter crossing; deasserts the cycle after clear or a ch_enable/warn_thresh change removes the condition.
REQ-027 Deasserting ch_enable[i] masks new events but retains err_flag[i] and err_count[i] values.
REQ-028 Monitoring state machine per capture path: IDLE (cleared) -> ARMED (clear pulse released) -> HIT (edge during window) -> IDLE on next clear pulse; an edge outside the window leaves ARMED.

Reset
REQ-029 reset asserted: capture flops, synchronizers, err_flag, err_count, alarm, first_valid, first_ch all 0 immediately; warning_signal 0.
REQ-030 reset mid-operation discards in-flight synchronizer events; no event counted after release from pre-reset hits.

Verification
REQ-031 N_CH=8, edge_mode=11, rising edge on ch3 with detec_window=1 -> warning_signal=1 same delta, err_flag=8'h08, err_count[3]=1, first_ch=3 after SYNC_STAGES+1 edges.
REQ-032 edge_mode=01, falling edge on ch0 in window -> no warning, counters unchanged; rising edge on ch0 outside window -> no warning.
REQ-033 CNT_W=4, 20 events on ch5 -> err_count[5]=15 (saturated); warn_thresh=3 -> alarm high one cycle after 3rd event.
REQ-034 Simultaneous events ch2 and ch6 -> first_ch=2, both flags set; clear same cycle as new ch6 event -> err_count[6]=1, others 0, first_ch=6.
REQ-035 ch_enable[1]=0 with edges on ch1 -> no warning/flag/count; reset asserted mid-count -> all outputs 0 at once, no post-release increment.
